// File: rtl/duck_round_ctrl.sv
// Game-flow controller for one duck-hunt game: turns button levels into click/start
// events and sequences rounds, shots, timers and the score/duck strobes.
module duck_round_ctrl #(
    parameter int SHOTS_PER_ROUND = 3,
    parameter int ROUNDS          = 10,
    parameter int ROUND_TICKS     = 300,
    parameter int PAUSE_TICKS     = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       mouse_left,
    input  logic       duck_hit,
    output logic       score_inc,
    output logic       score_clr,
    output logic       duck_respawn,
    output logic [3:0] shots_left,
    output logic [7:0] round_num,
    output logic       playing,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ROUND_START = 3'd1,
        S_PLAYING     = 3'd2,
        S_HIT_PAUSE   = 3'd3,
        S_ROUND_END   = 3'd4,
        S_GAME_OVER   = 3'd5
    } state_t;

    localparam logic [15:0] RT_LIM = 16'(ROUND_TICKS);
    localparam logic [15:0] PT_LIM = 16'(PAUSE_TICKS);
    localparam logic [3:0]  SHOTS  = 4'(SHOTS_PER_ROUND);
    localparam logic [7:0]  RN_LIM = 8'(ROUNDS);

    state_t      state_q, state_d;
    logic        mouse_left_d, start_btn_d;
    logic        click_evt, start_evt;
    logic [15:0] rtimer_q, rtimer_d, rtimer_inc;
    logic [15:0] ptimer_q, ptimer_d, ptimer_inc;
    logic [3:0]  shots_q, shots_d;
    logic [7:0]  round_q, round_d;
    logic        inc_d, clr_d, resp_d;

    assign click_evt = mouse_left & ~mouse_left_d;
    assign start_evt = start_btn & ~start_btn_d;

    // Saturating tick counts; the limit compare uses the post-increment value so the
    // transition happens in the same cycle as the terminal tick.
    assign rtimer_inc = (tick && rtimer_q != 16'hFFFF) ? rtimer_q + 16'd1 : rtimer_q;
    assign ptimer_inc = (tick && ptimer_q != 16'hFFFF) ? ptimer_q + 16'd1 : ptimer_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mouse_left_d <= 1'b1;
            start_btn_d  <= 1'b1;
            rtimer_q     <= '0;
            ptimer_q     <= '0;
            shots_q      <= '0;
            round_q      <= '0;
            score_inc    <= 1'b0;
            score_clr    <= 1'b0;
            duck_respawn <= 1'b0;
        end else begin
            state_q      <= state_d;
            mouse_left_d <= mouse_left;
            start_btn_d  <= start_btn;
            rtimer_q     <= rtimer_d;
            ptimer_q     <= ptimer_d;
            shots_q      <= shots_d;
            round_q      <= round_d;
            score_inc    <= inc_d;
            score_clr    <= clr_d;
            duck_respawn <= resp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rtimer_d = rtimer_q;
        ptimer_d = ptimer_q;
        shots_d  = shots_q;
        round_d  = round_q;
        inc_d    = 1'b0;
        clr_d    = 1'b0;
        resp_d   = 1'b0;
        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_evt) begin
                    clr_d   = 1'b1;
                    round_d = '0;
                    state_d = S_ROUND_START;
                end
            end
            S_ROUND_START: begin
                shots_d  = SHOTS;
                rtimer_d = '0;
                resp_d   = 1'b1;
                state_d  = S_PLAYING;
            end
            S_PLAYING: begin
                rtimer_d = rtimer_inc;
                // A click is resolved before a coincident timeout, so a hit still scores.
                if (click_evt && shots_q != 4'd0) begin
                    shots_d = shots_q - 4'd1;
                    if (duck_hit) begin
                        inc_d    = 1'b1;
                        ptimer_d = '0;
                        state_d  = S_HIT_PAUSE;
                    end else if (shots_q == 4'd1 || rtimer_inc >= RT_LIM) begin
                        state_d = S_ROUND_END;
                    end
                end else if (rtimer_inc >= RT_LIM) begin
                    state_d = S_ROUND_END;
                end
            end
            S_HIT_PAUSE: begin
                ptimer_d = ptimer_inc;
                if (ptimer_inc >= PT_LIM) state_d = S_ROUND_END;
            end
            S_ROUND_END: begin
                round_d = round_q + 8'd1;
                state_d = (round_q + 8'd1 == RN_LIM) ? S_GAME_OVER : S_ROUND_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign shots_left = shots_q;
    assign round_num  = round_q;
    assign playing    = (state_q == S_PLAYING);
    assign game_over  = (state_q == S_GAME_OVER);
    assign state      = state_q;

endmodule
